// File: rtl/cache_replace_plru.sv
// Victim-selection unit for N-way set-associative caches: per-set tree-PLRU
// state with a runtime-selectable 16-bit LFSR random mode.
module cache_replace_plru #(
    parameter int WAYS  = 4,
    parameter int SETS  = 256,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             query_valid,
    input  logic [IDX_W-1:0] query_set,
    input  logic [WAYS-1:0]  valid_way,
    input  logic             policy,
    input  logic             touch_valid,
    input  logic [IDX_W-1:0] touch_set,
    input  logic [WAYS-1:0]  touch_way,
    output logic             victim_valid,
    output logic [WAYS-1:0]  victim_way
);

    localparam int LVL   = $clog2(WAYS);
    localparam int NODES = WAYS - 1;

    logic [NODES-1:0] plru [SETS];
    logic [15:0]      lfsr;

    logic             touch_any;
    logic [LVL-1:0]   touch_idx;
    logic [NODES-1:0] touch_bits;
    logic [NODES-1:0] query_bits;
    logic             has_invalid;
    logic [LVL-1:0]   invalid_idx;
    logic [LVL-1:0]   victim_idx;
    logic             lfsr_fb;

    // Every node on the root-to-leaf path points away from the touched way.
    function automatic logic [NODES-1:0] touch_update(input logic [NODES-1:0] bits_in,
                                                      input logic [LVL-1:0]   way);
        logic [NODES-1:0] b;
        int unsigned      node;
        b    = bits_in;
        node = 0;
        for (int unsigned l = 0; l < LVL; l++) begin
            b[node] = ~way[LVL-1-l];
            node    = 2 * node + 1 + {31'd0, way[LVL-1-l]};
        end
        return b;
    endfunction

    function automatic logic [LVL-1:0] plru_walk(input logic [NODES-1:0] bits_in);
        logic [LVL-1:0] w;
        logic           d;
        int unsigned    node;
        w    = '0;
        node = 0;
        for (int unsigned l = 0; l < LVL; l++) begin
            d           = bits_in[node];
            w[LVL-1-l]  = d;
            node        = 2 * node + 1 + {31'd0, d};
        end
        return w;
    endfunction

    always_comb begin
        touch_any = 1'b0;
        touch_idx = '0;
        for (int unsigned i = WAYS; i > 0; i--) begin
            if (touch_way[i-1]) begin
                touch_any = 1'b1;
                touch_idx = LVL'(i - 1);
            end
        end
    end

    always_comb begin
        has_invalid = 1'b0;
        invalid_idx = '0;
        for (int unsigned i = WAYS; i > 0; i--) begin
            if (!valid_way[i-1]) begin
                has_invalid = 1'b1;
                invalid_idx = LVL'(i - 1);
            end
        end
    end

    assign touch_bits = touch_update(plru[touch_set], touch_idx);

    // Same-set touch in the query cycle is forwarded so the victim sees post-touch state.
    assign query_bits = (touch_valid && touch_any && (touch_set == query_set))
                        ? touch_bits : plru[query_set];

    always_comb begin
        if (has_invalid)
            victim_idx = invalid_idx;
        else if (policy)
            victim_idx = lfsr[LVL-1:0];
        else
            victim_idx = plru_walk(query_bits);
    end

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned s = 0; s < SETS; s++)
                plru[s] <= '0;
            lfsr         <= 16'h0001;
            victim_valid <= 1'b0;
            victim_way   <= '0;
        end else begin
            if (touch_valid && touch_any)
                plru[touch_set] <= touch_bits;
            if (query_valid)
                lfsr <= {lfsr[14:0], lfsr_fb};
            victim_valid <= query_valid;
            victim_way   <= query_valid ? ({{(WAYS-1){1'b0}}, 1'b1} << victim_idx) : '0;
        end
    end

endmodule

// File: tb/tb_cache_replace_plru.sv
// Self-checking bench for cache_replace_plru: directed scenarios plus a
// randomized stream checked against a range-halving tree model.
module tb_cache_replace_plru;

    localparam int WAYS  = 4;
    localparam int SETS  = 16;
    localparam int IDX_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             query_valid;
    logic [IDX_W-1:0] query_set;
    logic [WAYS-1:0]  valid_way;
    logic             policy;
    logic             touch_valid;
    logic [IDX_W-1:0] touch_set;
    logic [WAYS-1:0]  touch_way;
    logic             victim_valid;
    logic [WAYS-1:0]  victim_way;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: one bit per tree node per set, and the LFSR as an integer.
    bit m_bits [SETS][WAYS-1];
    int m_lfsr;
    logic            exp_valid;
    logic [WAYS-1:0] exp_way;

    cache_replace_plru #(.WAYS(WAYS), .SETS(SETS), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset),
        .query_valid(query_valid), .query_set(query_set), .valid_way(valid_way),
        .policy(policy), .touch_valid(touch_valid), .touch_set(touch_set),
        .touch_way(touch_way), .victim_valid(victim_valid), .victim_way(victim_way)
    );

    always #5 clock = ~clock;

    function automatic void model_touch(input int set, input logic [WAYS-1:0] tw);
        int w, lo, size, node, half;
        w = -1;
        for (int i = WAYS - 1; i >= 0; i--) if (tw[i]) w = i;
        if (w < 0) return;
        lo = 0; size = WAYS; node = 0;
        while (size > 1) begin
            half = size / 2;
            if (w < lo + half) begin
                m_bits[set][node] = 1'b1;
                node = 2 * node + 1;
            end else begin
                m_bits[set][node] = 1'b0;
                lo   = lo + half;
                node = 2 * node + 2;
            end
            size = half;
        end
    endfunction

    function automatic int model_victim(input int set, input logic [WAYS-1:0] vw, input logic pol);
        int lo, size, node, half;
        for (int i = 0; i < WAYS; i++) if (!vw[i]) return i;
        if (pol) return m_lfsr % WAYS;
        lo = 0; size = WAYS; node = 0;
        while (size > 1) begin
            half = size / 2;
            if (m_bits[set][node]) begin
                lo   = lo + half;
                node = 2 * node + 2;
            end else begin
                node = 2 * node + 1;
            end
            size = half;
        end
        return lo;
    endfunction

    // Drives one cycle of stimulus, advances one edge and updates the model.
    task automatic cycle(input logic rst, input logic qv, input int qs, input logic [WAYS-1:0] vw,
                         input logic pol, input logic tv, input int ts, input logic [WAYS-1:0] tw);
        int fb;
        reset = rst; query_valid = qv; query_set = IDX_W'(qs); valid_way = vw;
        policy = pol; touch_valid = tv; touch_set = IDX_W'(ts); touch_way = tw;
        @(posedge clock);
        if (rst) begin
            foreach (m_bits[s, n]) m_bits[s][n] = 1'b0;
            m_lfsr    = 1;
            exp_valid = 1'b0;
            exp_way   = '0;
        end else begin
            if (tv) model_touch(ts, tw);
            exp_valid = qv;
            exp_way   = qv ? (WAYS'(1) << model_victim(qs, vw, pol)) : '0;
            if (qv) begin
                fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
                m_lfsr = ((m_lfsr << 1) & 16'hFFFF) | fb;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 5, 4'hF, 0, 1, 5, 4'b0001);
        cycle(1, 0, 0, 4'hF, 0, 0, 0, 4'b0000);
        vectors++;
        if (victim_valid !== 1'b0 || victim_way !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b way=%b, expected valid=0 way=0000",
                     victim_valid, victim_way);
        end
        cycle(0, 1, 5, 4'hF, 0, 0, 0, 4'b0000);
        vectors++;
        if (victim_valid !== 1'b1 || victim_way !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_first_query: got valid=%b way=%b, expected valid=1 way=0001",
                     victim_valid, victim_way);
        end
        cycle(0, 0, 0, 4'hF, 0, 0, 0, 4'b0000);
        vectors++;
        if (victim_valid !== 1'b0 || victim_way !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_cycle_pulse: got valid=%b way=%b, expected valid=0 way=0000",
                     victim_valid, victim_way);
        end
    endtask

    task automatic test_touch_sequence();
        logic [WAYS-1:0] want [2];
        logic [WAYS-1:0] tws  [2];
        want[0] = 4'b0100; tws[0] = 4'b0001;
        want[1] = 4'b0010; tws[1] = 4'b0100;
        cycle(1, 0, 0, 4'hF, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 4'hF, 0, 1, 5, tws[i]);
            cycle(0, 1, 5, 4'hF, 0, 0, 0, 4'b0000);
            vectors++;
            if (victim_valid !== 1'b1 || victim_way !== want[i]) begin
                miscompares++;
                $display("FAIL touch_seq%0d: got valid=%b way=%b, expected valid=1 way=%b",
                         i, victim_valid, victim_way, want[i]);
            end
        end
    endtask

    task automatic test_invalid_ways();
        logic [WAYS-1:0] vws  [3];
        logic            pols [3];
        logic [WAYS-1:0] want [3];
        vws[0] = 4'b1011; pols[0] = 1'b0; want[0] = 4'b0100;
        vws[1] = 4'b1011; pols[1] = 1'b1; want[1] = 4'b0100;
        vws[2] = 4'b0000; pols[2] = 1'b0; want[2] = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 5, vws[i], pols[i], 0, 0, 4'b0000);
            vectors++;
            if (victim_valid !== 1'b1 || victim_way !== want[i]) begin
                miscompares++;
                $display("FAIL invalid_way%0d: got valid=%b way=%b, expected valid=1 way=%b",
                         i, victim_valid, victim_way, want[i]);
            end
        end
    endtask

    task automatic test_random_mode();
        logic [WAYS-1:0] want [4];
        want[0] = 4'b0010; want[1] = 4'b0100; want[2] = 4'b0001; want[3] = 4'b0001;
        cycle(1, 0, 0, 4'hF, 1, 0, 0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, i, 4'hF, 1, 0, 0, 4'b0000);
            vectors++;
            if (victim_valid !== 1'b1 || victim_way !== want[i]) begin
                miscompares++;
                $display("FAIL lfsr_step%0d: got valid=%b way=%b, expected valid=1 way=%b",
                         i, victim_valid, victim_way, want[i]);
            end
        end
    endtask

    task automatic test_bypass();
        int              qsets [2];
        logic [WAYS-1:0] want  [2];
        qsets[0] = 3; want[0] = 4'b0100;
        qsets[1] = 4; want[1] = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            cycle(1, 0, 0, 4'hF, 0, 0, 0, 4'b0000);
            cycle(0, 1, qsets[i], 4'hF, 0, 1, 3, 4'b0001);
            vectors++;
            if (victim_valid !== 1'b1 || victim_way !== want[i]) begin
                miscompares++;
                $display("FAIL bypass_set%0d: got valid=%b way=%b, expected valid=1 way=%b",
                         qsets[i], victim_valid, victim_way, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        cycle(1, 0, 0, 4'hF, 0, 0, 0, 4'b0000);
        cycle(0, 1, 1, 4'hF, 1, 1, 5, 4'b0001);
        cycle(0, 1, 2, 4'hF, 1, 1, 6, 4'b1000);
        cycle(0, 1, 5, 4'hF, 0, 0, 0, 4'b0000);
        cycle(1, 1, 5, 4'hF, 0, 0, 0, 4'b0000);
        vectors++;
        if (victim_valid !== 1'b0 || victim_way !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_valid: got valid=%b way=%b, expected valid=0 way=0000",
                     victim_valid, victim_way);
        end
        cycle(0, 1, 5, 4'hF, 1, 0, 0, 4'b0000);
        vectors++;
        if (victim_way !== 4'b0010) begin
            miscompares++;
            $display("FAIL midreset_lfsr: got way=%b, expected way=0010", victim_way);
        end
        for (int s = 5; s <= 6; s++) begin
            cycle(0, 1, s, 4'hF, 0, 0, 0, 4'b0000);
            vectors++;
            if (victim_way !== 4'b0001) begin
                miscompares++;
                $display("FAIL midreset_plru_set%0d: got way=%b, expected way=0001", s, victim_way);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic            rst, qv, pol, tv;
        int              qs, ts;
        logic [WAYS-1:0] vw, tw;
        cycle(1, 0, 0, 4'hF, 0, 0, 0, 4'b0000);
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            qv  = ($urandom_range(0, 3) != 0);
            qs  = $urandom_range(0, 3);
            vw  = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : 4'hF;
            pol = $urandom_range(0, 1);
            tv  = ($urandom_range(0, 2) != 0);
            ts  = $urandom_range(0, 3);
            tw  = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : (WAYS'(1) << $urandom_range(0, 3));
            cycle(rst, qv, qs, vw, pol, tv, ts, tw);
            vectors++;
            if (victim_valid !== exp_valid || victim_way !== exp_way) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got valid=%b way=%b, expected valid=%b way=%b",
                         n, victim_valid, victim_way, exp_valid, exp_way);
            end
        end
    endtask

    initial begin
        test_reset();
        test_touch_sequence();
        test_invalid_ways();
        test_random_mode();
        test_bypass();
        test_reset_mid_stream();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_replace_plru.md
# cache_replace_plru

Parametrised victim-selection unit for N-way set-associative caches. It replaces the fixed 2-way selectors with one block that keeps per-set tree-PLRU state internally and offers a runtime-selectable LFSR random mode. ICache and DCache query it on a miss to get a one-hot fill way, and report every hit or fill back as a touch so the LRU state stays current.

## Interface
- WAYS, 4, associativity; power of two, 2..8
- SETS, 256, number of sets; power of two
- IDX_W, log2(SETS), set index width (derived)
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- query_valid  in  1  victim request this cycle
- query_set  in  IDX_W  set being filled
- valid_way  in  WAYS  per-way valid bits of query_set (bit i = way i)
- policy  in  1  0 = tree-PLRU, 1 = LFSR random; sampled with query_valid
- touch_valid  in  1  access (hit or fill) to record
- touch_set  in  IDX_W  set accessed
- touch_way  in  WAYS  one-hot way accessed
- victim_valid  out  1  victim_way valid this cycle
- victim_way  out  WAYS  one-hot way to replace

## Operation
- State: SETS × (WAYS−1) PLRU bits held in flops, plus a 16-bit LFSR.
- Tree layout: node 0 is the root. The children of node n are 2n+1 and 2n+2. Leaves in left-to-right order are ways 0..WAYS−1. Bit value 0 means "LRU is on the left"; 1 means "LRU is on the right".
- Victim priority:
  1. If any valid_way bit is 0, the victim is the lowest-index invalid way, in both modes.
  2. Otherwise, in PLRU mode, walk from the root following the bits of query_set. The leaf reached is the victim.
  3. Otherwise, in random mode, the victim is way lfsr[log2(WAYS)−1:0].
- Touch: when touch_valid is 1, every node on the path to touch_way is set to point away from it (bit = 1 if the touched way lies in the left subtree, else 0). Nodes off the path are unchanged. The update applies in both policy modes.
- Malformed touch: if touch_way is zero, no update. If touch_way has more than one bit set, the lowest set bit is used.
- Bypass: if touch_valid and query_valid are both 1 in the same cycle with the same set, the victim is computed from the post-touch bits.
- LFSR: Fibonacci, taps x^16+x^14+x^13+x^11.
  - Update: lfsr ← {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - It advances on every cycle with query_valid = 1, regardless of policy.
  - The victim uses the pre-advance value.
- WAYS = 2 degenerates to a single bit per set, giving exact LRU.

## Timing
- Reset values: all PLRU bits 0; lfsr = 16'h0001; victim_valid = 0; victim_way = 0.
- Query latency is 1 cycle. A query at edge k produces victim_valid = 1 and victim_way after edge k, held for exactly one cycle. victim_way returns to 0 when victim_valid is 0.
- Back-to-back queries are supported every cycle; there is no backpressure.
- Touch state is written at the clock edge and visible to any query in the next cycle; same-set queries in the same cycle see it via the bypass.
- Simultaneous touch and query to different sets are independent.
- Reset asserted mid-operation:
  - At the next edge, all state and outputs take their reset values.
  - A query presented during reset yields no victim_valid.
- victim_way is always one-hot whenever victim_valid = 1.

## Test plan
- Reset, WAYS=4, all ways valid, query set 5, PLRU mode -> victim_way = 4'b0001 one cycle later.
- Touch set 5 way0, then query -> 4'b0100 (bits b0=1, b1=1). Touch way2, then query -> 4'b0010 (b0=0, b2=1).
- valid_way = 4'b1011 in either mode -> 4'b0100. valid_way = 4'b0000 -> 4'b0001.
- Random mode from reset, all valid, query on consecutive cycles -> victims way1, way2, way0, way0 (lfsr 0001, 0002, 0004, 0008).
- Same-cycle touch of set 3 way0 plus query of set 3, state at reset -> victim 4'b0100 (bypass). Same stimulus with query of set 4 instead -> 4'b0001.
- Assert reset during a query stream -> victim_valid = 0 the cycle after. Previously touched sets return 4'b0001; the LFSR restarts at way1.
